// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage for the 32-bit ARM core.
//
// Owns the fetch PC and issues one word request at a time to instruction
// memory. Returned words are pushed into a small prefetch queue whose head
// is presented to decode. A taken branch flushes the queue, retargets the
// fetch PC, and drops the response of any request already in flight.
//
// Parameters:
//   RESET_PC  fetch address after reset (word aligned)
//   DEPTH     prefetch queue entries (power of two, >= 2)
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   imem_req/addr     request valid and word address (held until accepted)
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid/rdata response valid and instruction word
//   instr, instr_pc   head-of-queue instruction and its address
//   pc_plus8          instr_pc + 8 (architectural PC read value)
//   instr_valid       head entry valid
//   instr_ready       decode consumes the head this cycle
//   branch_taken      redirect request (PCSrc)
//   branch_target     redirect address, low two bits ignored
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state;
  logic          req_q;
  logic [31:0]   req_addr;
  logic [31:0]   fetch_pc;
  logic          discard;

  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;
  logic [31:0]   target;

  assign target = branch_target & 32'hFFFF_FFFC;
  assign accept = (state == REQ) && imem_ready;
  assign resp   = (state == WAIT) && imem_rvalid;
  // A response is dropped if it belongs to a flushed request or if the
  // flush arrives in the same cycle as the response.
  assign push   = resp && !discard && !branch_taken;
  assign pop    = instr_valid && instr_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      req_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (branch_taken) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push)
          tail <= tail + PW'(1);
        if (pop)
          head <= head + PW'(1);
        count <= count_nxt;
      end

      // While discard is set the accepted request is stale and fetch_pc
      // already holds the redirect address, so it must not advance.
      if (branch_taken)
        fetch_pc <= target;
      else if (accept && !discard)
        fetch_pc <= fetch_pc + 32'd4;

      // Any arriving response consumes the pending discard, even when a new
      // flush lands in the same cycle: nothing is in flight afterwards.
      if (resp)
        discard <= 1'b0;
      else if (branch_taken && (state != IDLE))
        discard <= 1'b1;

      // Request address is only loaded on entry to REQ, so a flush while
      // REQ is pending leaves imem_addr untouched until the handshake.
      unique case (state)
        IDLE: begin
          if (branch_taken || (count < CW'(DEPTH))) begin
            state    <= REQ;
            req_q    <= 1'b1;
            req_addr <= branch_taken ? target : fetch_pc;
          end
        end
        REQ: begin
          if (accept) begin
            state <= WAIT;
            req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (resp) begin
            if (branch_taken || (count_nxt < CW'(DEPTH))) begin
              state    <= REQ;
              req_q    <= 1'b1;
              req_addr <= branch_taken ? target : fetch_pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Queue storage carries no reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= req_addr;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = req_addr;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_instr[head] : 32'd0;
  assign instr_pc    = instr_valid ? q_pc[head] : 32'd0;
  assign pc_plus8    = instr_pc + 32'd8;

endmodule
